// File: rtl/ps2_keyboard_ascii.sv
// PS/2 set-2 keyboard receiver: deserialises frames, tracks F0/E0 prefixes and
// presents the last pressed key as a held uppercase ASCII character.
module ps2_keyboard_ascii #(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] ascii,
  output logic       ascii_valid,
  output logic       frame_error
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] data_sync;
  logic                   clk_prev;
  logic [2:0]             bit_cnt;
  logic [7:0]             shift;
  logic                   parity;
  logic                   brk;
  logic                   ext;
  logic [TW-1:0]          tcount;

  logic       clk_s;
  logic       data_s;
  logic       fall;
  logic       frame_ok;
  logic [8:0] mapped;

  assign clk_s    = clk_sync[SYNC_STAGES-1];
  assign data_s   = data_sync[SYNC_STAGES-1];
  assign fall     = clk_prev & ~clk_s;
  assign frame_ok = data_s & (^{shift, parity});
  assign mapped   = lookup(shift);

  // Returns {mapped, character}; bit 8 clear means the code has no ASCII meaning.
  function automatic logic [8:0] lookup(input logic [7:0] code);
    case (code)
      8'h1C: lookup = {1'b1, 8'h41};
      8'h32: lookup = {1'b1, 8'h42};
      8'h21: lookup = {1'b1, 8'h43};
      8'h23: lookup = {1'b1, 8'h44};
      8'h24: lookup = {1'b1, 8'h45};
      8'h2B: lookup = {1'b1, 8'h46};
      8'h34: lookup = {1'b1, 8'h47};
      8'h33: lookup = {1'b1, 8'h48};
      8'h43: lookup = {1'b1, 8'h49};
      8'h3B: lookup = {1'b1, 8'h4A};
      8'h42: lookup = {1'b1, 8'h4B};
      8'h4B: lookup = {1'b1, 8'h4C};
      8'h3A: lookup = {1'b1, 8'h4D};
      8'h31: lookup = {1'b1, 8'h4E};
      8'h44: lookup = {1'b1, 8'h4F};
      8'h4D: lookup = {1'b1, 8'h50};
      8'h15: lookup = {1'b1, 8'h51};
      8'h2D: lookup = {1'b1, 8'h52};
      8'h1B: lookup = {1'b1, 8'h53};
      8'h2C: lookup = {1'b1, 8'h54};
      8'h3C: lookup = {1'b1, 8'h55};
      8'h2A: lookup = {1'b1, 8'h56};
      8'h1D: lookup = {1'b1, 8'h57};
      8'h22: lookup = {1'b1, 8'h58};
      8'h35: lookup = {1'b1, 8'h59};
      8'h1A: lookup = {1'b1, 8'h5A};
      8'h45: lookup = {1'b1, 8'h30};
      8'h16: lookup = {1'b1, 8'h31};
      8'h1E: lookup = {1'b1, 8'h32};
      8'h26: lookup = {1'b1, 8'h33};
      8'h25: lookup = {1'b1, 8'h34};
      8'h2E: lookup = {1'b1, 8'h35};
      8'h36: lookup = {1'b1, 8'h36};
      8'h3D: lookup = {1'b1, 8'h37};
      8'h3E: lookup = {1'b1, 8'h38};
      8'h46: lookup = {1'b1, 8'h39};
      8'h29: lookup = {1'b1, 8'h20};
      default: lookup = 9'h000;
    endcase
  endfunction

  // Idle line level is high, so synchronisers reset to 1 to avoid a false fall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_sync  <= '1;
      data_sync <= '1;
      clk_prev  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
      clk_prev  <= clk_s;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      bit_cnt     <= 3'd0;
      shift       <= 8'h00;
      parity      <= 1'b0;
      brk         <= 1'b0;
      ext         <= 1'b0;
      tcount      <= '0;
      ascii       <= 8'h00;
      ascii_valid <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      ascii_valid <= 1'b0;
      frame_error <= 1'b0;
      if (fall) begin
        tcount <= '0;
        case (state)
          IDLE: begin
            if (!data_s) begin
              state   <= DATA;
              bit_cnt <= 3'd0;
            end
          end
          DATA: begin
            shift   <= {data_s, shift[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            parity <= data_s;
            state  <= STOP;
          end
          STOP: begin
            state <= IDLE;
            // A byte following a prefix only consumes the prefix; errors keep prefixes.
            if (!frame_ok) begin
              frame_error <= 1'b1;
            end else if (shift == 8'hF0) begin
              brk <= 1'b1;
            end else if (shift == 8'hE0) begin
              ext <= 1'b1;
            end else if (brk || ext) begin
              brk <= 1'b0;
              ext <= 1'b0;
            end else if (mapped[8]) begin
              ascii       <= mapped[7:0];
              ascii_valid <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end else if (state == IDLE) begin
        tcount <= '0;
      end else if (tcount == TW'(TIMEOUT_CYCLES)) begin
        state  <= IDLE;
        tcount <= '0;
      end else begin
        tcount <= tcount + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ps2_keyboard_ascii.sv
// Self-checking bench for ps2_keyboard_ascii: table of frames plus hand-written
// timeout, reset and latency sequences, with a pulse scoreboard.
module tb_ps2_keyboard_ascii;

  localparam int TIMEOUT = 300;
  localparam int HP      = 25;
  localparam int SYNC    = 2;

  localparam logic [1:0] K_NONE  = 2'd0;
  localparam logic [1:0] K_VALID = 2'd1;
  localparam logic [1:0] K_ERR   = 2'd2;

  logic       clk = 1'b0;
  logic       reset;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] ascii;
  logic       ascii_valid;
  logic       frame_error;

  typedef struct {
    logic [1:0] kind;
    logic [7:0] ch;
  } exp_t;

  typedef struct {
    logic [7:0] code;
    logic       bad_par;
    logic       bad_stop;
    logic [1:0] kind;
    logic [7:0] exp_ascii;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[$];
  int   total = 0;
  int   bad   = 0;
  int   lat;

  ps2_keyboard_ascii #(.TIMEOUT_CYCLES(TIMEOUT), .SYNC_STAGES(SYNC)) dut (
    .clk        (clk),
    .reset      (reset),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .ascii      (ascii),
    .ascii_valid(ascii_valid),
    .frame_error(frame_error)
  );

  always #10 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic exp_t popExp();
    exp_t e;
    e.kind = K_NONE;
    e.ch   = 8'h00;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    return e;
  endfunction

  function automatic void pushExp(input logic [1:0] kind, input logic [7:0] ch);
    exp_t e;
    e.kind = kind;
    e.ch   = ch;
    exp_q.push_back(e);
  endfunction

  // Every output pulse consumes one expected event; a stretched pulse consumes two.
  always @(negedge clk) begin
    exp_t e;
    if (ascii_valid) begin
      e = popExp();
      checkOutput("valid_pulse_kind", K_VALID, e.kind);
      if (e.kind == K_VALID) checkOutput("valid_pulse_ascii", ascii, e.ch);
    end
    if (frame_error) begin
      e = popExp();
      checkOutput("error_pulse_kind", K_ERR, e.kind);
    end
  end

  task automatic ps2Bit(input logic b);
    @(negedge clk);
    ps2_data = b;
    repeat (HP / 2) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (HP) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (HP / 2) @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [7:0] code, input logic bad_par, input logic bad_stop);
    logic p;
    p = (~(^code)) ^ bad_par;
    ps2Bit(1'b0);
    for (int i = 0; i < 8; i++) ps2Bit(code[i]);
    ps2Bit(p);
    ps2Bit(~bad_stop);
    @(negedge clk);
    ps2_data = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  // Sends a good frame and counts negedges from the raw stop-bit fall to ascii_valid.
  task automatic sendMeasured(input logic [7:0] code, output int latency);
    ps2Bit(1'b0);
    for (int i = 0; i < 8; i++) ps2Bit(code[i]);
    ps2Bit(~(^code));
    @(negedge clk);
    ps2_data = 1'b1;
    repeat (HP / 2) @(negedge clk);
    ps2_clk = 1'b0;
    latency = -1;
    for (int k = 1; k <= HP; k++) begin
      @(negedge clk);
      if (ascii_valid) begin
        latency = k;
        break;
      end
    end
    repeat (5) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  function automatic vec_t mk(input logic [7:0] code, input logic bp, input logic bs,
                              input logic [1:0] kind, input logic [7:0] ea);
    vec_t v;
    v.code = code; v.bad_par = bp; v.bad_stop = bs; v.kind = kind; v.exp_ascii = ea;
    return v;
  endfunction

  initial begin
    vecs.push_back(mk(8'h2B, 0, 0, K_VALID, 8'h46));
    vecs.push_back(mk(8'h24, 0, 0, K_VALID, 8'h45));
    vecs.push_back(mk(8'hF0, 0, 0, K_NONE,  8'h45));
    vecs.push_back(mk(8'h24, 0, 0, K_NONE,  8'h45));
    vecs.push_back(mk(8'h23, 1, 0, K_ERR,   8'h45));
    vecs.push_back(mk(8'h32, 0, 0, K_VALID, 8'h42));
    vecs.push_back(mk(8'hE0, 0, 0, K_NONE,  8'h42));
    vecs.push_back(mk(8'h1C, 0, 0, K_NONE,  8'h42));
    vecs.push_back(mk(8'h1C, 0, 0, K_VALID, 8'h41));
    vecs.push_back(mk(8'h45, 0, 0, K_VALID, 8'h30));
    vecs.push_back(mk(8'h1A, 0, 0, K_VALID, 8'h5A));
    vecs.push_back(mk(8'h29, 0, 0, K_VALID, 8'h20));
    vecs.push_back(mk(8'h29, 0, 0, K_VALID, 8'h20));
    vecs.push_back(mk(8'h16, 0, 0, K_VALID, 8'h31));
    vecs.push_back(mk(8'h76, 0, 0, K_NONE,  8'h31));
    vecs.push_back(mk(8'h2D, 0, 1, K_ERR,   8'h31));
    vecs.push_back(mk(8'hE0, 0, 0, K_NONE,  8'h31));
    vecs.push_back(mk(8'h1C, 1, 0, K_ERR,   8'h31));
    vecs.push_back(mk(8'h2D, 0, 0, K_NONE,  8'h31));
    vecs.push_back(mk(8'h2D, 0, 0, K_VALID, 8'h52));

    reset    = 1'b1;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset_ascii", ascii, 8'h00);
    checkOutput("reset_valid", ascii_valid, 1'b0);
    checkOutput("reset_error", frame_error, 1'b0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].kind != K_NONE) pushExp(vecs[i].kind, vecs[i].exp_ascii);
      applyStimulus(vecs[i].code, vecs[i].bad_par, vecs[i].bad_stop);
      checkOutput($sformatf("row%0d_ascii", i), ascii, vecs[i].exp_ascii);
      checkOutput($sformatf("row%0d_pending", i), exp_q.size(), 0);
    end

    // Abandoned partial frame must be dropped silently by the timeout.
    pushExp(K_VALID, 8'h44);
    applyStimulus(8'h23, 0, 0);
    ps2Bit(1'b0);
    ps2Bit(1'b1);
    ps2Bit(1'b0);
    ps2Bit(1'b1);
    repeat (TIMEOUT + 100) @(negedge clk);
    checkOutput("timeout_pending", exp_q.size(), 0);
    pushExp(K_VALID, 8'h52);
    applyStimulus(8'h2D, 0, 0);
    checkOutput("timeout_ascii", ascii, 8'h52);
    checkOutput("timeout_after_pending", exp_q.size(), 0);

    // Reset in the middle of a frame clears outputs at once.
    ps2Bit(1'b0);
    ps2Bit(1'b1);
    ps2Bit(1'b1);
    ps2Bit(1'b0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("midreset_ascii", ascii, 8'h00);
    checkOutput("midreset_valid", ascii_valid, 1'b0);
    checkOutput("midreset_error", frame_error, 1'b0);
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // Two synchroniser stages see the pin fall, one more cycle registers the output.
    pushExp(K_VALID, 8'h44);
    sendMeasured(8'h23, lat);
    checkOutput("latency", lat, SYNC + 1);
    checkOutput("post_reset_ascii", ascii, 8'h44);
    checkOutput("final_pending", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
